// File: rtl/imem_loader.sv
`default_nettype none
//==============================================================================
// Module : imem_loader
// Desc   : UART (8N1) program loader: framed image -> big-endian IMEM word writes.
//          Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// Rev    : 1.0
//==============================================================================
module imem_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        SYS_clk,
    input  logic        SYS_rst,
    input  logic        uart_rx,
    input  logic        load_en,
    output logic        LDR_we,
    output logic [7:0]  LDR_addr,
    output logic [31:0] LDR_wdata,
    output logic        LDR_busy,
    output logic        LDR_done,
    output logic        LDR_err,
    output logic [7:0]  LDR_count
);
    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE} ldr_state_t;

    rx_state_t            r_rx_state, w_rx_nxt;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_rx_byte;
    logic                 r_byte_valid, r_frame_err;
    logic                 w_fall, w_cnt_hit;

    ldr_state_t           r_state, w_state_nxt;
    logic                 r_we, r_err, r_hold;
    logic [7:0]           r_addr, r_count, r_nwords;
    logic [31:0]          r_wdata;
    logic [1:0]           r_byte_idx;
    logic                 w_start, w_set_err, w_take_n, w_take_data, w_last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    assign w_fall    = r_rx_prev & ~r_rx_sync;
    assign w_cnt_hit = (r_rx_state == RX_START) ? (r_clk_cnt == c_HALF_LAST)
                                                : (r_clk_cnt == c_BIT_LAST);

    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_fall) w_rx_nxt = RX_START;
            RX_START: if (w_cnt_hit) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_cnt_hit && r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
            RX_STOP:  if (w_cnt_hit) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_rx_byte    <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_rx_state   <= w_rx_nxt;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_rx_state == RX_IDLE || w_cnt_hit)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;
            if (r_rx_state == RX_START)
                r_bit_idx <= 3'd0;
            if (r_rx_state == RX_DATA && w_cnt_hit) begin
                r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_rx_state == RX_STOP && w_cnt_hit) begin
                r_byte_valid <= r_rx_sync;
                r_frame_err  <= ~r_rx_sync;
            end
        end
    end

    // N=0 encodes 256 words, so N-1 wrapping to 255 marks the last address.
    assign w_last_word = (r_count == r_nwords - 8'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_set_err   = 1'b0;
        w_take_n    = 1'b0;
        w_take_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_en && !r_hold) begin
                    w_state_nxt = S_COUNT;
                    w_start     = 1'b1;
                end
            end
            S_COUNT: begin
                if (!load_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_frame_err) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else if (r_byte_valid) begin
                    w_state_nxt = S_DATA;
                    w_take_n    = 1'b1;
                end
            end
            S_DATA: begin
                if (!load_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_frame_err) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else begin
                    w_take_data = r_byte_valid;
                    if (r_we && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (!load_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_frame_err) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else if (r_byte_valid) begin
                    if (r_rx_byte == r_csum) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_set_err   = 1'b1;
                    end
                end
            end
`endif
            S_DONE:  if (!load_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= 1'b0;
            r_addr     <= 8'd0;
            r_count    <= 8'd0;
            r_nwords   <= 8'd0;
            r_wdata    <= 32'd0;
            r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_err      <= 1'b0;
                r_addr     <= 8'd0;
                r_count    <= 8'd0;
                r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end
            if (w_take_n)
                r_nwords <= r_rx_byte;
            if (w_take_data) begin
                case (r_byte_idx)
                    2'd0:    r_wdata[31:24] <= r_rx_byte;
                    2'd1:    r_wdata[23:16] <= r_rx_byte;
                    2'd2:    r_wdata[15:8]  <= r_rx_byte;
                    default: r_wdata[7:0]   <= r_rx_byte;
                endcase
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3)
                    r_we <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum <= r_csum ^ r_rx_byte;
`endif
            end
            if (r_we) begin
                r_addr  <= r_addr + 8'd1;
                r_count <= r_count + 8'd1;
            end
            // After an error the session stays parked until load_en is released.
            if (w_set_err) begin
                r_err  <= 1'b1;
                r_hold <= 1'b1;
            end else if (!load_en) begin
                r_hold <= 1'b0;
            end
        end
    end

    assign LDR_we    = r_we;
    assign LDR_addr  = r_addr;
    assign LDR_wdata = r_wdata;
    assign LDR_count = r_count;
    assign LDR_err   = r_err;
    assign LDR_done  = (r_state == S_DONE);
    assign LDR_busy  = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Serial program loader that writes the instruction memory, the writer side of the IMEM read port used by the CPU datapath. It receives a framed image over a UART line (8N1, LSB first), assembles big-endian 32-bit words and issues one-cycle write strobes at consecutive word addresses from 0. While loading it holds the CPU through `LDR_busy`. The system gates PC reset with `LDR_busy`, so execution restarts at PC 0 after a load.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: SYS_clk cycles per UART bit (50 MHz / 115200). Minimum 4.

Ports:
- `SYS_clk`, in, 1: system clock, rising edge.
- `SYS_rst`, in, 1: asynchronous, active-low reset.
- `uart_rx`, in, 1: serial input, idle high, asynchronous to SYS_clk.
- `load_en`, in, 1: level; high requests and sustains a load session.
- `LDR_we`, out, 1: IMEM write strobe, one cycle per word.
- `LDR_addr`, out, 8: IMEM word address for the current/next write.
- `LDR_wdata`, out, 32: word to write, valid when `LDR_we`=1.
- `LDR_busy`, out, 1: session active; CPU held.
- `LDR_done`, out, 1: image complete and accepted.
- `LDR_err`, out, 1: sticky error (framing, or checksum when enabled).
- `LDR_count`, out, 8: words written this session (mod 256).

## Operation
- The receiver synchronises `uart_rx` through 2 flops.
- **Start detection:** a falling edge (synced 1→0) starts a frame. The line is re-sampled at CLKS_PER_BIT/2 (integer division). If it is high, the event is a glitch and the receiver returns to idle.
- **Bit sampling:** 8 data bits are sampled every CLKS_PER_BIT after that point, LSB first. The stop bit is then sampled.
  - Stop bit = 1: emit an internal `byte_valid` pulse for one cycle.
  - Stop bit = 0: framing error.
- **IDLE:** `LDR_busy`=0. When `load_en`=1 (and `LDR_done`=0):
  - Go to COUNT.
  - Clear `LDR_err`, `LDR_count`, `LDR_addr` and the byte index.
- **COUNT:** the first byte is N, the number of words. N=0 means 256. Go to DATA.
- **DATA:** bytes fill `LDR_wdata[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` in that order.
  - On the 4th byte, pulse `LDR_we`.
  - On the cycle after the pulse, `LDR_addr` and `LDR_count` increment, and the byte index resets.
  - After the Nth word, go to CHECK (if enabled) or DONE.
- **DONE:** `LDR_done`=1 and `LDR_busy`=0. Stay here until `load_en`=0, then go to IDLE and clear `LDR_done`.
- **Framing error** in any busy state:
  - Set `LDR_err` and go to IDLE.
  - `LDR_done` stays 0.
  - A new session starts only after `load_en` goes 0 and back to 1.
- **`load_en` falls during COUNT/DATA/CHECK:** abort to IDLE next cycle. No further `LDR_we`; `LDR_err` is unchanged.
- **Address wrap:** with N=256 the addresses run 0..255. The wrap to 0 after the last word is not used, because the block enters DONE.
- **Line held low (break):** treated as a start, then a framing error.

## Timing
- Reset values: `LDR_we`=0, `LDR_addr`=0, `LDR_wdata`=0, `LDR_busy`=0, `LDR_done`=0, `LDR_err`=0, `LDR_count`=0. The FSM is in IDLE and the receiver is idle.
- `LDR_busy` rises 1 cycle after `load_en` is sampled high in IDLE.
- `byte_valid` occurs 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling edge on the pin.
- `LDR_we` is asserted the cycle after the `byte_valid` of the 4th byte.
  - `LDR_addr` and `LDR_wdata` are stable during that cycle.
  - `LDR_addr` increments on the next cycle.
- `LDR_done` rises, and `LDR_busy` falls, in the same cycle, one cycle after the last `LDR_we` (or after the checksum byte is accepted).
- Reset mid-operation: all outputs return to reset values immediately. A partial word is never written.
- `byte_valid` and a `load_en` fall in the same cycle: the abort wins and no `LDR_we` is issued.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
  - **Defined:** after the Nth word the FSM enters CHECK and expects one further byte equal to the XOR of all 4N data bytes (N byte excluded).
    - Match: go to DONE.
    - Mismatch: set `LDR_err` and go to IDLE. `LDR_done` stays 0. The words already written remain in IMEM.
  - **Undefined:** there is no CHECK state and DONE follows the Nth word directly.

## Test plan
- **Reset:** pulse SYS_rst low mid-byte → all outputs 0 immediately; no `LDR_we` afterwards.
- **Single word:** `load_en`=1, send 0x01, 0x24, 0x08, 0x00, 0x05 (plus checksum 0x29 if enabled) → exactly one `LDR_we` with `LDR_addr`=0x00 and `LDR_wdata`=0x24080005. Then `LDR_done`=1, `LDR_count`=1, `LDR_busy`=0.
- **Three words:** send 0x03 and 12 bytes → `LDR_we` at addresses 0, 1, 2 with correct words, and `LDR_count`=3.
- **Framing error:** corrupt the stop bit of the 2nd data byte → `LDR_err`=1, no `LDR_we`, FSM in IDLE, `LDR_done`=0.
- **Abort and glitch:** drop `load_en` after 2 of 4 bytes → `LDR_busy`=0 next cycle, no `LDR_we`. Then a 0.2-bit low glitch on `uart_rx` in IDLE → no byte received.
- **Checksum (macro defined):** a wrong checksum byte after 1 word → `LDR_err`=1, `LDR_done`=0, one `LDR_we` already issued.
